// File: rtl/rob_superscalar.sv
// -----------------------------------------------------------------------------
// rob_superscalar
//   N-way reorder buffer between dispatch, the CDB and the architectural
//   regfile. Allocates up to WAYS entries per cycle in program order, records
//   up to CDB_WAYS completions per cycle, retires up to WAYS consecutive done
//   entries from the head, squashes everything younger than a mispredicted
//   branch, and serves tag-indexed operand lookups with CDB bypass.
//
// Ports
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   dis_valid          per-way dispatch request (way 0 oldest)
//   dis_dest_idx       per-way architectural destination register
//   dis_tag            tag offered to way k: tail + k
//   dis_num_free       min(free entries, WAYS)
//   cdb_valid/tag/value completion ports
//   squash_valid/tag   mispredict recovery; squash_tag survives
//   rd_tag             operand lookup tags
//   rd_ready/rd_value  lookup result, CDB bypass first
//   ret_valid          retiring ways, contiguous from way 0
//   ret_dest_idx/value retiring destination register and value
//   full, empty        occupancy flags
// -----------------------------------------------------------------------------
module rob_superscalar #(
   parameter int ROB_DEPTH = 32,
   parameter int WAYS      = 2,
   parameter int CDB_WAYS  = 2,
   parameter int RD_PORTS  = 2,
   parameter int XLEN      = 32,
   parameter int REG_IDX_W = 5
) (
   input  logic                                   clock,
   input  logic                                   reset_n,
   input  logic [WAYS-1:0]                        dis_valid,
   input  logic [WAYS*REG_IDX_W-1:0]              dis_dest_idx,
   output logic [WAYS*$clog2(ROB_DEPTH)-1:0]      dis_tag,
   output logic [$clog2(WAYS):0]                  dis_num_free,
   input  logic [CDB_WAYS-1:0]                    cdb_valid,
   input  logic [CDB_WAYS*$clog2(ROB_DEPTH)-1:0]  cdb_tag,
   input  logic [CDB_WAYS*XLEN-1:0]               cdb_value,
   input  logic                                   squash_valid,
   input  logic [$clog2(ROB_DEPTH)-1:0]           squash_tag,
   input  logic [RD_PORTS*$clog2(ROB_DEPTH)-1:0]  rd_tag,
   output logic [RD_PORTS-1:0]                    rd_ready,
   output logic [RD_PORTS*XLEN-1:0]               rd_value,
   output logic [WAYS-1:0]                        ret_valid,
   output logic [WAYS*REG_IDX_W-1:0]              ret_dest_idx,
   output logic [WAYS*XLEN-1:0]                   ret_value,
   output logic                                   full,
   output logic                                   empty
);

   localparam int TAG_W = $clog2(ROB_DEPTH);
   localparam int CNT_W = TAG_W + 1;
   localparam int NF_W  = $clog2(WAYS) + 1;

   // ---------------------------------------------------------------- state
   logic [TAG_W-1:0]     r_head;
   logic [TAG_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;
   logic [ROB_DEPTH-1:0] r_busy;
   logic [ROB_DEPTH-1:0] r_done;
   logic [REG_IDX_W-1:0] r_dest  [ROB_DEPTH];
   logic [XLEN-1:0]      r_value [ROB_DEPTH];

   // ---------------------------------------------------------------- wires
   logic [CNT_W-1:0]     w_free;
   logic                 w_sq_act;
   logic [TAG_W-1:0]     w_sq_off;
   logic [WAYS-1:0]      w_dis_acc;
   logic [CNT_W-1:0]     w_acc_cnt;
   logic                 w_acc_run;
   logic [CNT_W-1:0]     w_ret_cnt;
   logic                 w_ret_run;
   logic [TAG_W-1:0]     w_ridx;
   logic [ROB_DEPTH-1:0] w_busy_nxt;
   logic [ROB_DEPTH-1:0] w_done_nxt;
   logic [TAG_W-1:0]     w_koff;
   logic [TAG_W-1:0]     w_ctag;
   logic [TAG_W-1:0]     w_rtag;
   logic                 w_hit;
   logic [CNT_W-1:0]     w_count_nxt;
   logic                 w_cdb_dup;

   assign w_free   = CNT_W'(ROB_DEPTH) - r_count;
   assign w_sq_act = squash_valid && r_busy[squash_tag];
   // Age of the squash point relative to head; younger entries have a larger offset.
   assign w_sq_off = squash_tag - r_head;

   assign full         = (r_count == CNT_W'(ROB_DEPTH));
   assign empty        = (r_count == '0);
   assign dis_num_free = (w_free >= CNT_W'(WAYS)) ? NF_W'(WAYS) : NF_W'(w_free);

   // ------------------------------------------------------------- dispatch
   // Acceptance stops at the first gap or once free slots run out; a squash
   // cycle accepts nothing.
   always_comb begin
      w_acc_run = 1'b1;
      w_acc_cnt = '0;
      w_dis_acc = '0;
      dis_tag   = '0;
      for (int unsigned k = 0; k < WAYS; k++) begin
         dis_tag[k*TAG_W +: TAG_W] = r_tail + TAG_W'(k);
         if (w_acc_run && dis_valid[k] && (CNT_W'(k) < w_free) && !w_sq_act) begin
            w_dis_acc[k] = 1'b1;
            w_acc_cnt    = w_acc_cnt + CNT_W'(1);
         end else begin
            w_acc_run = 1'b0;
         end
      end
   end

   // --------------------------------------------------------------- retire
   always_comb begin
      w_ret_run    = 1'b1;
      w_ret_cnt    = '0;
      w_ridx       = '0;
      ret_valid    = '0;
      ret_dest_idx = '0;
      ret_value    = '0;
      for (int unsigned k = 0; k < WAYS; k++) begin
         w_ridx = r_head + TAG_W'(k);
         if (w_ret_run && r_busy[w_ridx] && r_done[w_ridx]) begin
            ret_valid[k]                           = 1'b1;
            ret_dest_idx[k*REG_IDX_W +: REG_IDX_W] = r_dest[w_ridx];
            ret_value[k*XLEN +: XLEN]              = r_value[w_ridx];
            w_ret_cnt                              = w_ret_cnt + CNT_W'(1);
         end else begin
            w_ret_run = 1'b0;
         end
      end
   end

   // ----------------------------------------------------- busy/done update
   // Order matters: completions first, then retire clears, then the squash
   // kill (so CDB writes to killed entries vanish), then new allocations.
   always_comb begin
      w_busy_nxt = r_busy;
      w_done_nxt = r_done;
      w_ctag     = '0;
      w_koff     = '0;
      for (int unsigned p = 0; p < CDB_WAYS; p++) begin
         w_ctag = cdb_tag[p*TAG_W +: TAG_W];
         if (cdb_valid[p] && r_busy[w_ctag]) begin
            w_done_nxt[w_ctag] = 1'b1;
         end
      end
      for (int unsigned k = 0; k < WAYS; k++) begin
         if (ret_valid[k]) begin
            w_busy_nxt[r_head + TAG_W'(k)] = 1'b0;
            w_done_nxt[r_head + TAG_W'(k)] = 1'b0;
         end
      end
      if (w_sq_act) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            w_koff = TAG_W'(i) - r_head;
            if (w_koff > w_sq_off) begin
               w_busy_nxt[i] = 1'b0;
               w_done_nxt[i] = 1'b0;
            end
         end
      end
      for (int unsigned k = 0; k < WAYS; k++) begin
         if (w_dis_acc[k]) begin
            w_busy_nxt[r_tail + TAG_W'(k)] = 1'b1;
            w_done_nxt[r_tail + TAG_W'(k)] = 1'b0;
         end
      end
   end

   assign w_count_nxt = w_sq_act ? (CNT_W'(w_sq_off) + CNT_W'(1) - w_ret_cnt)
                                 : (r_count + w_acc_cnt - w_ret_cnt);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_busy  <= '0;
         r_done  <= '0;
      end else begin
         r_head  <= r_head + TAG_W'(w_ret_cnt);
         r_tail  <= w_sq_act ? (squash_tag + TAG_W'(1)) : (r_tail + TAG_W'(w_acc_cnt));
         r_count <= w_count_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Payload storage carries no reset; busy/done qualify every read.
   always_ff @(posedge clock) begin
      for (int unsigned k = 0; k < WAYS; k++) begin
         if (w_dis_acc[k]) begin
            r_dest[r_tail + TAG_W'(k)] <= dis_dest_idx[k*REG_IDX_W +: REG_IDX_W];
         end
      end
      for (int unsigned p = 0; p < CDB_WAYS; p++) begin
         if (cdb_valid[p] && r_busy[cdb_tag[p*TAG_W +: TAG_W]]) begin
            r_value[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_value[p*XLEN +: XLEN];
         end
      end
   end

   // --------------------------------------------------------------- lookup
   // Lowest-index matching CDB port wins over the stored entry.
   always_comb begin
      rd_ready = '0;
      rd_value = '0;
      w_rtag   = '0;
      w_hit    = 1'b0;
      for (int unsigned r = 0; r < RD_PORTS; r++) begin
         w_rtag                   = rd_tag[r*TAG_W +: TAG_W];
         w_hit                    = 1'b0;
         rd_ready[r]              = r_done[w_rtag];
         rd_value[r*XLEN +: XLEN] = r_value[w_rtag];
         for (int unsigned p = 0; p < CDB_WAYS; p++) begin
            if (!w_hit && cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == w_rtag)) begin
               w_hit                    = 1'b1;
               rd_ready[r]              = 1'b1;
               rd_value[r*XLEN +: XLEN] = cdb_value[p*XLEN +: XLEN];
            end
         end
      end
   end

   // ------------------------------------------------------------ assertion
   always_comb begin
      w_cdb_dup = 1'b0;
      for (int unsigned i = 0; i < CDB_WAYS; i++) begin
         for (int unsigned j = i + 1; j < CDB_WAYS; j++) begin
            if (cdb_valid[i] && cdb_valid[j] &&
                (cdb_tag[i*TAG_W +: TAG_W] == cdb_tag[j*TAG_W +: TAG_W])) begin
               w_cdb_dup = 1'b1;
            end
         end
      end
   end

   a_cdb_unique_tag: assert property (@(posedge clock) disable iff (!reset_n) !w_cdb_dup);

endmodule

// File: tb/tb_rob_superscalar.sv
// -----------------------------------------------------------------------------
// tb_rob_superscalar
//   Self-checking bench for rob_superscalar (32 entries, 2-wide). A retire
//   monitor compares each retiring way against a program-order scoreboard;
//   hand-written sequences cover reset, out-of-order completion, squash and
//   bypass; a vector table drives the wrap-around fill to full.
// -----------------------------------------------------------------------------
module tb_rob_superscalar;

   localparam int DEPTH = 32;
   localparam int WAYS  = 2;
   localparam int CDBW  = 2;
   localparam int RDP   = 2;
   localparam int XLEN  = 32;
   localparam int RIW   = 5;
   localparam int TW    = 5;

   logic                 clock;
   logic                 reset_n;
   logic [WAYS-1:0]      dis_valid;
   logic [WAYS*RIW-1:0]  dis_dest_idx;
   logic [WAYS*TW-1:0]   dis_tag;
   logic [1:0]           dis_num_free;
   logic [CDBW-1:0]      cdb_valid;
   logic [CDBW*TW-1:0]   cdb_tag;
   logic [CDBW*XLEN-1:0] cdb_value;
   logic                 squash_valid;
   logic [TW-1:0]        squash_tag;
   logic [RDP*TW-1:0]    rd_tag;
   logic [RDP-1:0]       rd_ready;
   logic [RDP*XLEN-1:0]  rd_value;
   logic [WAYS-1:0]      ret_valid;
   logic [WAYS*RIW-1:0]  ret_dest_idx;
   logic [WAYS*XLEN-1:0] ret_value;
   logic                 full;
   logic                 empty;

   rob_superscalar #(
      .ROB_DEPTH (DEPTH),
      .WAYS      (WAYS),
      .CDB_WAYS  (CDBW),
      .RD_PORTS  (RDP),
      .XLEN      (XLEN),
      .REG_IDX_W (RIW)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .dis_valid    (dis_valid),
      .dis_dest_idx (dis_dest_idx),
      .dis_tag      (dis_tag),
      .dis_num_free (dis_num_free),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_value    (cdb_value),
      .squash_valid (squash_valid),
      .squash_tag   (squash_tag),
      .rd_tag       (rd_tag),
      .rd_ready     (rd_ready),
      .rd_value     (rd_value),
      .ret_valid    (ret_valid),
      .ret_dest_idx (ret_dest_idx),
      .ret_value    (ret_value),
      .full         (full),
      .empty        (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          tag;
      logic [RIW-1:0] dest;
   } sb_t;

   typedef struct {
      logic [1:0] dv;
      int         acc;
      int         tag0;
      int         tag1;
      int         nfree;
      logic       full;
      logic       empty;
   } vec_t;

   sb_t         sbq[$];
   sb_t         m_e;
   vec_t        vt[20];
   logic [31:0] exp_val[DEPTH];
   int          exp_tail;
   int          dest_ctr;
   int          n_checks;
   int          n_errors;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_cdb(input logic [1:0] v, input int t0, input logic [31:0] v0,
                          input int t1, input logic [31:0] v1);
      cdb_valid = v;
      cdb_tag   = {TW'(t1), TW'(t0)};
      cdb_value = {v1, v0};
      if (v[0]) exp_val[t0] = v0;
      if (v[1]) exp_val[t1] = v1;
   endtask

   task automatic clr_cdb();
      cdb_valid = '0;
      cdb_tag   = '0;
      cdb_value = '0;
   endtask

   task automatic push_sb(input int n);
      sb_t e;
      for (int k = 0; k < n; k++) begin
         e.tag  = (exp_tail + k) % DEPTH;
         e.dest = RIW'(dest_ctr + k);
         sbq.push_back(e);
      end
   endtask

   // Dispatch one cycle; n_acc is how many ways the bench expects accepted.
   task automatic dispatch(input logic [1:0] dv, input int n_acc);
      chk("dis_tag0", dis_tag[TW-1:0], exp_tail);
      dis_valid    = dv;
      dis_dest_idx = {RIW'(dest_ctr + 1), RIW'(dest_ctr)};
      push_sb(n_acc);
      tick();
      dis_valid = '0;
      exp_tail  = (exp_tail + n_acc) % DEPTH;
      dest_ctr += 2;
   endtask

   task automatic complete_pair(input int t0, input int t1);
      set_cdb(2'b11, t0, 32'h1000 + t0 * 3, t1, 32'h1000 + t1 * 3);
      tick();
      clr_cdb();
   endtask

   task automatic wait_empty(input string name, input int bound);
      for (int i = 0; i < bound && !empty; i++) tick();
      chk(name, empty, 1);
   endtask

   // Retire monitor: every retiring way must match the scoreboard head.
   always @(negedge clock) begin
      if (reset_n) begin
         chk("ret_contiguous", (ret_valid == 2'b10), 0);
         for (int k = 0; k < WAYS; k++) begin
            if (ret_valid[k]) begin
               if (sbq.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL ret_extra: got retire on way %0d expected none at %0t", k, $time);
               end else begin
                  m_e = sbq.pop_front();
                  chk("ret_dest", ret_dest_idx[k*RIW +: RIW], m_e.dest);
                  chk("ret_value", ret_value[k*XLEN +: XLEN], exp_val[m_e.tag]);
               end
            end
         end
      end
   end

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      exp_tail     = 0;
      dest_ctr     = 3;
      reset_n      = 1'b0;
      dis_valid    = '0;
      dis_dest_idx = '0;
      squash_valid = 1'b0;
      squash_tag   = '0;
      rd_tag       = '0;
      clr_cdb();
      for (int i = 0; i < DEPTH; i++) exp_val[i] = '0;

      // Wrap-around fill table: tail starts at 30 when it is applied.
      vt[0] = '{dv: 2'b10, acc: 0, tag0: 30, tag1: 31, nfree: 2, full: 1'b0, empty: 1'b1};
      vt[1] = '{dv: 2'b00, acc: 0, tag0: 30, tag1: 31, nfree: 2, full: 1'b0, empty: 1'b1};
      for (int i = 0; i < 16; i++)
         vt[2+i] = '{dv: 2'b11, acc: 2, tag0: (30 + 2*i) % DEPTH, tag1: (31 + 2*i) % DEPTH,
                     nfree: 2, full: 1'b0, empty: (i == 0)};
      vt[18] = '{dv: 2'b11, acc: 0, tag0: 30, tag1: 31, nfree: 0, full: 1'b1, empty: 1'b0};
      vt[19] = '{dv: 2'b01, acc: 0, tag0: 30, tag1: 31, nfree: 0, full: 1'b1, empty: 1'b0};

      // ---- reset state
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ret_valid", ret_valid, 0);
      chk("rst_num_free", dis_num_free, 2);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_tag1", dis_tag[2*TW-1:TW], 1);
      tick();

      // ---- out-of-order completion, no CDB-to-retire bypass
      dispatch(2'b11, 2);
      dispatch(2'b11, 2);
      set_cdb(2'b01, 3, 32'hA3, 0, 0);
      tick();
      clr_cdb();
      chk("ooo_none_yet", ret_valid, 2'b00);
      set_cdb(2'b01, 0, 32'hA0, 0, 0);
      #1;
      chk("ooo_no_bypass", ret_valid, 2'b00);
      tick();
      clr_cdb();
      chk("ooo_tag0_alone", ret_valid, 2'b01);
      set_cdb(2'b01, 1, 32'hA1, 0, 0);
      #1;
      chk("ooo_tag0_still_alone", ret_valid, 2'b01);
      tick();
      clr_cdb();
      chk("ooo_tag1_alone", ret_valid, 2'b01);
      tick();
      chk("ooo_tag3_waits", ret_valid, 2'b00);
      set_cdb(2'b01, 2, 32'hA2, 0, 0);
      tick();
      clr_cdb();
      chk("ooo_tag2_tag3", ret_valid, 2'b11);
      tick();
      chk("ooo_empty", empty, 1);
      chk("ooo_tail", dis_tag[TW-1:0], 4);

      // ---- asynchronous reset mid-run with 5 entries live
      dispatch(2'b11, 2);
      dispatch(2'b11, 2);
      dispatch(2'b01, 1);
      chk("mid_num_free", dis_num_free, 2);
      set_cdb(2'b01, 4, 32'h44, 0, 0);
      tick();
      clr_cdb();
      chk("mid_ret_before_rst", ret_valid, 2'b01);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_ret_valid", ret_valid, 0);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_num_free", dis_num_free, 2);
      sbq.delete();
      exp_tail = 0;
      tick();
      tick();
      #2;
      reset_n = 1'b1;
      tick();

      // ---- bypass then squash with tags 0..7 busy
      dispatch(2'b11, 2);
      dispatch(2'b11, 2);
      dispatch(2'b11, 2);
      dispatch(2'b11, 2);
      rd_tag = {TW'(7), TW'(6)};
      set_cdb(2'b10, 0, 0, 6, 32'hDEAD);
      #1;
      chk("byp_ready", rd_ready, 2'b01);
      chk("byp_value", rd_value[XLEN-1:0], 32'hDEAD);
      tick();
      clr_cdb();
      chk("byp_stored_ready", rd_ready[0], 1);
      chk("byp_stored_value", rd_value[XLEN-1:0], 32'hDEAD);
      squash_valid = 1'b1;
      squash_tag   = TW'(3);
      dis_valid    = 2'b11;
      tick();
      squash_valid = 1'b0;
      dis_valid    = '0;
      for (int i = 0; i < 4; i++) void'(sbq.pop_back());
      exp_tail = 4;
      chk("sq_tail", dis_tag[TW-1:0], 4);
      chk("sq_killed_done", rd_ready[0], 0);
      set_cdb(2'b01, 5, 32'h55, 0, 0);
      tick();
      clr_cdb();
      rd_tag = {TW'(0), TW'(5)};
      #1;
      chk("sq_cdb_ignored", rd_ready[0], 0);
      chk("sq_tail_hold", dis_tag[TW-1:0], 4);
      complete_pair(0, 1);
      complete_pair(2, 3);
      wait_empty("sq_drain_empty", 10);
      chk("sq_sb_empty", sbq.size(), 0);
      chk("sq_head_tail", dis_tag[TW-1:0], 4);

      // ---- advance head/tail to 30 through a long dispatch/complete run
      for (int i = 0; i < 13; i++) dispatch(2'b11, 2);
      for (int i = 0; i < 13; i++) complete_pair(4 + 2*i, 5 + 2*i);
      wait_empty("run_empty", 20);
      chk("run_tail", dis_tag[TW-1:0], 30);

      // ---- table-driven fill to full, across the wrap
      for (int i = 0; i < 20; i++) begin
         dis_valid    = vt[i].dv;
         dis_dest_idx = {RIW'(dest_ctr + 1), RIW'(dest_ctr)};
         #1;
         chk("fill_tag0", dis_tag[TW-1:0], vt[i].tag0);
         chk("fill_tag1", dis_tag[2*TW-1:TW], vt[i].tag1);
         chk("fill_num_free", dis_num_free, vt[i].nfree);
         chk("fill_full", full, vt[i].full);
         chk("fill_empty", empty, vt[i].empty);
         push_sb(vt[i].acc);
         tick();
         dis_valid = '0;
         exp_tail  = (exp_tail + vt[i].acc) % DEPTH;
         dest_ctr += 2;
      end
      for (int i = 0; i < 16; i++) complete_pair((30 + 2*i) % DEPTH, (31 + 2*i) % DEPTH);
      wait_empty("fill_drain_empty", 40);
      chk("fill_sb_empty", sbq.size(), 0);
      chk("fill_final_tail", dis_tag[TW-1:0], 30);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
